// File: rtl/sdc_host_arb.sv
// Round-robin arbiter that lets two hosts share the single request/data port of sdc_top.
// It grants one host per burst and steers the controller's beat strobes back to that host.
module sdc_host_arb #(
  parameter int AW = 22,
  parameter int DW = 32
) (
  input  logic            mclk,
  input  logic            s_resetn,
  input  logic [1:0]      h_req,
  input  logic [2*AW-1:0] h_adr,
  input  logic [3:0]      h_len,
  input  logic [1:0]      h_wr_n,
  input  logic [2*DW-1:0] h_wr_data,
  input  logic [7:0]      h_wr_en_n,
  output logic [1:0]      h_ack,
  output logic [1:0]      h_wr_next,
  output logic [1:0]      h_rd_valid,
  output logic [DW-1:0]   h_rd_data,
  input  logic            sdr_init_done,
  output logic            sdr_req,
  output logic [AW-1:0]   sdr_req_adr,
  output logic [1:0]      sdr_req_len,
  output logic            sdr_req_wr_n,
  output logic [DW-1:0]   sdr_wr_data,
  output logic [3:0]      sdr_wr_en_n,
  input  logic            sdr_req_ack,
  input  logic            sdr_wr_next,
  input  logic            sdr_rd_valid,
  input  logic [DW-1:0]   sdr_rd_data,
  output logic            arb_err
);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          req_q, req_d;
  logic          wr_n_q, wr_n_d;
  logic          err_q, err_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [1:0]    len_q, len_d;
  logic [AW-1:0] adr_q, adr_d;

  logic gnt;
  logic busy;
  logic cnt_en;
  logic last_beat;

  // On a tie the host that did not win last time gets the grant.
  assign gnt       = (h_req == 2'b11) ? ~last_q : h_req[1];
  assign busy      = (state_q != IDLE);
  assign cnt_en    = busy & (wr_n_q ? sdr_rd_valid : sdr_wr_next);
  assign last_beat = cnt_en & (cnt_q == len_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    req_d   = req_q;
    wr_n_d  = wr_n_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    adr_d   = adr_q;
    case (state_q)
      IDLE: begin
        if (sdr_wr_next | sdr_rd_valid) err_d = 1'b1;
        if (sdr_init_done && (h_req != 2'b00)) begin
          owner_d = gnt;
          last_d  = gnt;
          adr_d   = gnt ? h_adr[AW +: AW] : h_adr[0 +: AW];
          len_d   = gnt ? h_len[3:2] : h_len[1:0];
          wr_n_d  = h_wr_n[gnt];
          cnt_d   = 2'd0;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // Beats may arrive before or together with the ack; both count.
        if (cnt_en) cnt_d = cnt_q + 2'd1;
        if (sdr_req_ack) begin
          req_d = 1'b0;
          if (last_beat) begin
            cnt_d   = 2'd0;
            state_d = IDLE;
          end else begin
            state_d = XFER;
          end
        end
      end
      XFER: begin
        if (cnt_en) cnt_d = cnt_q + 2'd1;
        if (last_beat) begin
          cnt_d   = 2'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge s_resetn) begin
    if (!s_resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      req_q   <= 1'b0;
      wr_n_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 2'd0;
      len_q   <= 2'd0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      req_q   <= req_d;
      wr_n_q  <= wr_n_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      adr_q   <= adr_d;
    end
  end

  always_comb begin
    h_ack       = 2'b00;
    h_wr_next   = 2'b00;
    h_rd_valid  = 2'b00;
    sdr_wr_data = '0;
    sdr_wr_en_n = 4'hF;
    if (busy) begin
      h_wr_next[owner_q]  = sdr_wr_next;
      h_rd_valid[owner_q] = sdr_rd_valid;
      sdr_wr_data         = owner_q ? h_wr_data[DW +: DW] : h_wr_data[0 +: DW];
      sdr_wr_en_n         = owner_q ? h_wr_en_n[7:4] : h_wr_en_n[3:0];
    end
    if ((state_q == REQ) && sdr_req_ack) h_ack[owner_q] = 1'b1;
  end

  assign h_rd_data    = sdr_rd_data;
  assign sdr_req      = req_q;
  assign sdr_req_adr  = adr_q;
  assign sdr_req_len  = len_q;
  assign sdr_req_wr_n = wr_n_q;
  assign arb_err      = err_q;

endmodule

// File: tb/tb_sdc_host_arb.sv
// Bench for sdc_host_arb: plays both hosts and the SDRAM controller, predicting grants
// from the round-robin rule and beat counts from the burst length code.
module tb_sdc_host_arb;
  localparam int AW = 22;
  localparam int DW = 32;

  logic            mclk = 1'b0;
  logic            s_resetn = 1'b0;
  logic [1:0]      h_req = 2'b00;
  logic [AW-1:0]   hadr [2];
  logic [1:0]      hlen [2];
  logic            hwrn [2];
  logic [DW-1:0]   hwd  [2];
  logic [3:0]      hbe  [2];
  logic [2*AW-1:0] h_adr;
  logic [3:0]      h_len;
  logic [1:0]      h_wr_n;
  logic [2*DW-1:0] h_wr_data;
  logic [7:0]      h_wr_en_n;
  logic [1:0]      h_ack, h_wr_next, h_rd_valid;
  logic [DW-1:0]   h_rd_data;
  logic            sdr_init_done = 1'b1;
  logic            sdr_req;
  logic [AW-1:0]   sdr_req_adr;
  logic [1:0]      sdr_req_len;
  logic            sdr_req_wr_n;
  logic [DW-1:0]   sdr_wr_data;
  logic [3:0]      sdr_wr_en_n;
  logic            sdr_req_ack = 1'b0;
  logic            sdr_wr_next = 1'b0;
  logic            sdr_rd_valid = 1'b0;
  logic [DW-1:0]   sdr_rd_data = '0;
  logic            arb_err;

  int errs = 0;
  int checks = 0;
  int m_last = 1;

  assign h_adr     = {hadr[1], hadr[0]};
  assign h_len     = {hlen[1], hlen[0]};
  assign h_wr_n    = {hwrn[1], hwrn[0]};
  assign h_wr_data = {hwd[1], hwd[0]};
  assign h_wr_en_n = {hbe[1], hbe[0]};

  sdc_host_arb #(.AW(AW), .DW(DW)) dut (
    .mclk(mclk), .s_resetn(s_resetn), .h_req(h_req), .h_adr(h_adr), .h_len(h_len),
    .h_wr_n(h_wr_n), .h_wr_data(h_wr_data), .h_wr_en_n(h_wr_en_n), .h_ack(h_ack),
    .h_wr_next(h_wr_next), .h_rd_valid(h_rd_valid), .h_rd_data(h_rd_data),
    .sdr_init_done(sdr_init_done), .sdr_req(sdr_req), .sdr_req_adr(sdr_req_adr),
    .sdr_req_len(sdr_req_len), .sdr_req_wr_n(sdr_req_wr_n), .sdr_wr_data(sdr_wr_data),
    .sdr_wr_en_n(sdr_wr_en_n), .sdr_req_ack(sdr_req_ack), .sdr_wr_next(sdr_wr_next),
    .sdr_rd_valid(sdr_rd_valid), .sdr_rd_data(sdr_rd_data), .arb_err(arb_err)
  );

  always #5 mclk = ~mclk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  task automatic nxt();
    @(posedge mclk);
    @(negedge mclk);
  endtask

  task automatic clr();
    sdr_wr_next  = 1'b0;
    sdr_rd_valid = 1'b0;
  endtask

  task automatic set_host(input int h, input logic [AW-1:0] a, input logic [1:0] l, input logic wn);
    hadr[h] = a;
    hlen[h] = l;
    hwrn[h] = wn;
  endtask

  // Round-robin reference: a lone requester wins; on a tie the other-than-last host wins.
  function automatic int pick(input logic [1:0] r);
    if (r == 2'b11) return 1 - m_last;
    return r[1] ? 1 : 0;
  endfunction

  // One beat cycle: cnt drives the strobe matching the burst direction, oth the opposite one.
  task automatic strobe(input int w, input bit cnt, input bit oth);
    logic [1:0] ev;
    ev = (w == 1) ? 2'b10 : 2'b01;
    hwd[0] = $urandom();
    hwd[1] = $urandom();
    hbe[0] = 4'($urandom_range(0, 15));
    hbe[1] = 4'($urandom_range(0, 15));
    sdr_rd_data = $urandom();
    if (hwrn[w]) begin
      sdr_rd_valid = cnt;
      sdr_wr_next  = oth;
    end else begin
      sdr_wr_next  = cnt;
      sdr_rd_valid = oth;
    end
    #1;
    checks++;
    if (h_wr_next !== (sdr_wr_next ? ev : 2'b00) || h_rd_valid !== (sdr_rd_valid ? ev : 2'b00) ||
        sdr_wr_data !== hwd[w] || sdr_wr_en_n !== hbe[w] || h_rd_data !== sdr_rd_data) begin
      errs++;
      $display("FAIL steer host%0d: wr_next=%b rd_valid=%b wdata=%h be=%h rdata=%h, want %b %b %h %h %h",
               w, h_wr_next, h_rd_valid, sdr_wr_data, sdr_wr_en_n, h_rd_data,
               sdr_wr_next ? ev : 2'b00, sdr_rd_valid ? ev : 2'b00, hwd[w], hbe[w], sdr_rd_data);
    end
  endtask

  // Entered on the cycle sdr_req is expected high for host w; returns once back in IDLE.
  task automatic serve_burst(input int w, input int ack_dly, input bit coinc, input bit drop);
    int need, beats;
    bit c;
    logic [1:0] ev;
    ev = (w == 1) ? 2'b10 : 2'b01;
    need = int'(hlen[w]) + 1;
    beats = 0;
    m_last = w;
    #1;
    checks++;
    if (sdr_req !== 1'b1 || sdr_req_adr !== hadr[w] || sdr_req_len !== hlen[w] || sdr_req_wr_n !== hwrn[w]) begin
      errs++;
      $display("FAIL grant host%0d: req=%b adr=%h len=%0d wr_n=%b, want 1 %h %0d %b",
               w, sdr_req, sdr_req_adr, sdr_req_len, sdr_req_wr_n, hadr[w], hlen[w], hwrn[w]);
    end
    for (int i = 0; i < ack_dly; i++) begin
      c = (beats < need - 1) && ($urandom_range(0, 1) == 1);
      strobe(w, c, 1'b0);
      if (c) beats++;
      nxt();
      clr();
      #1;
      checks++;
      if (sdr_req !== 1'b1 || h_ack !== 2'b00 || sdr_req_adr !== hadr[w]) begin
        errs++;
        $display("FAIL req_hold host%0d: req=%b ack=%b adr=%h, want 1 00 %h", w, sdr_req, h_ack, sdr_req_adr, hadr[w]);
      end
    end
    sdr_req_ack = 1'b1;
    if (coinc) begin
      strobe(w, 1'b1, 1'b0);
      beats++;
    end else begin
      #1;
    end
    checks++;
    if (h_ack !== ev) begin
      errs++;
      $display("FAIL h_ack host%0d: got %b want %b", w, h_ack, ev);
    end
    nxt();
    sdr_req_ack = 1'b0;
    clr();
    if (drop) h_req[w] = 1'b0;
    if (beats < need) begin
      #1;
      checks++;
      if (sdr_req !== 1'b0 || h_ack !== 2'b00) begin
        errs++;
        $display("FAIL req_drop host%0d: req=%b ack=%b want 0 00", w, sdr_req, h_ack);
      end
    end
    while (beats < need) begin
      repeat ($urandom_range(0, 2)) begin
        strobe(w, 1'b0, 1'($urandom_range(0, 1)));
        nxt();
        clr();
      end
      strobe(w, 1'b1, 1'b0);
      beats++;
      nxt();
      clr();
    end
    #1;
    checks++;
    if (sdr_req !== 1'b0 || sdr_wr_en_n !== 4'hF || sdr_wr_data !== '0) begin
      errs++;
      $display("FAIL idle_after host%0d: req=%b be=%h wdata=%h want 0 f 0", w, sdr_req, sdr_wr_en_n, sdr_wr_data);
    end
  endtask

  task automatic test_reset();
    nxt();
    nxt();
    #1;
    checks++;
    if (sdr_req !== 1'b0 || h_ack !== 2'b00 || arb_err !== 1'b0 || sdr_req_adr !== '0 ||
        sdr_req_len !== 2'd0 || sdr_req_wr_n !== 1'b0 || sdr_wr_en_n !== 4'hF || sdr_wr_data !== '0) begin
      errs++;
      $display("FAIL reset: req=%b ack=%b err=%b adr=%h len=%0d wr_n=%b be=%h wdata=%h",
               sdr_req, h_ack, arb_err, sdr_req_adr, sdr_req_len, sdr_req_wr_n, sdr_wr_en_n, sdr_wr_data);
    end
    s_resetn = 1'b1;
    m_last = 1;
    nxt();
  endtask

  task automatic test_alternate();
    set_host(0, 22'h0000A0, 2'd1, 1'b1);
    set_host(1, 22'h0000B4, 2'd1, 1'b1);
    h_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      int w;
      w = pick(h_req);
      nxt();
      serve_burst(w, k % 2, 1'b0, 1'b0);
    end
    h_req = 2'b00;
    nxt();
  endtask

  task automatic test_write_burst();
    set_host(0, 22'h000100, 2'd3, 1'b0);
    set_host(1, 22'h3FFFFC, 2'd2, 1'b1);
    h_req = 2'b01;
    nxt();
    serve_burst(pick(2'b01), 0, 1'b0, 1'b1);
    nxt();
  endtask

  task automatic test_init_block();
    sdr_init_done = 1'b0;
    set_host(0, 22'h001234, 2'd2, 1'b0);
    h_req = 2'b01;
    for (int i = 0; i < 20; i++) begin
      nxt();
      #1;
      checks++;
      if (sdr_req !== 1'b0) begin
        errs++;
        $display("FAIL init_block cyc%0d: req=%b want 0", i, sdr_req);
      end
    end
    sdr_init_done = 1'b1;
    nxt();
    serve_burst(pick(h_req), 1, 1'b0, 1'b1);
    nxt();
  endtask

  task automatic test_len0_coincident();
    set_host(1, 22'h0ABCDE, 2'd0, 1'b1);
    h_req = 2'b10;
    nxt();
    serve_burst(pick(h_req), 0, 1'b1, 1'b0);
    nxt();
    serve_burst(pick(h_req), 0, 1'b1, 1'b1);
    nxt();
  endtask

  task automatic test_init_drop();
    set_host(1, 22'h002000, 2'd3, 1'b0);
    h_req = 2'b10;
    nxt();
    sdr_init_done = 1'b0;
    serve_burst(pick(h_req), 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      #1;
      checks++;
      if (sdr_req !== 1'b0) begin
        errs++;
        $display("FAIL init_drop cyc%0d: req=%b want 0", i, sdr_req);
      end
    end
    sdr_init_done = 1'b1;
    nxt();
    serve_burst(pick(h_req), 0, 1'b0, 1'b1);
    nxt();
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int w;
      for (int h = 0; h < 2; h++) begin
        if (!h_req[h] && $urandom_range(0, 1) == 1) begin
          set_host(h, AW'($urandom()), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
          h_req[h] = 1'b1;
        end
      end
      if (h_req == 2'b00) begin
        set_host(0, AW'($urandom()), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        h_req[0] = 1'b1;
      end
      w = pick(h_req);
      nxt();
      serve_burst(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
    end
    h_req = 2'b00;
    nxt();
    #1;
    checks++;
    if (arb_err !== 1'b0) begin
      errs++;
      $display("FAIL err_clean: arb_err=%b want 0", arb_err);
    end
  endtask

  task automatic test_err();
    sdr_wr_next = 1'b1;
    #1;
    checks++;
    if (h_wr_next !== 2'b00) begin
      errs++;
      $display("FAIL idle_wr_next: h_wr_next=%b want 00", h_wr_next);
    end
    nxt();
    clr();
    #1;
    checks++;
    if (arb_err !== 1'b1) begin
      errs++;
      $display("FAIL err_set: arb_err=%b want 1", arb_err);
    end
    sdr_rd_valid = 1'b1;
    #1;
    checks++;
    if (h_rd_valid !== 2'b00) begin
      errs++;
      $display("FAIL idle_rd_valid: h_rd_valid=%b want 00", h_rd_valid);
    end
    nxt();
    clr();
    repeat (5) nxt();
    #1;
    checks++;
    if (arb_err !== 1'b1) begin
      errs++;
      $display("FAIL err_sticky: arb_err=%b want 1", arb_err);
    end
  endtask

  task automatic test_async_reset();
    set_host(0, 22'h000400, 2'd3, 1'b0);
    h_req = 2'b01;
    nxt();
    #1;
    checks++;
    if (sdr_req !== 1'b1) begin
      errs++;
      $display("FAIL ar_grant: req=%b want 1", sdr_req);
    end
    sdr_req_ack = 1'b1;
    nxt();
    sdr_req_ack = 1'b0;
    h_req = 2'b00;
    repeat (2) begin
      sdr_wr_next = 1'b1;
      nxt();
      clr();
    end
    set_host(1, 22'h000800, 2'd1, 1'b1);
    h_req = 2'b11;
    sdr_wr_next = 1'b1;
    #2;
    s_resetn = 1'b0;
    #1;
    checks++;
    if (sdr_req !== 1'b0 || h_wr_next !== 2'b00 || h_rd_valid !== 2'b00 || h_ack !== 2'b00 ||
        arb_err !== 1'b0 || sdr_req_adr !== '0 || sdr_wr_en_n !== 4'hF) begin
      errs++;
      $display("FAIL async_reset: req=%b wr_next=%b rd_valid=%b ack=%b err=%b adr=%h be=%h",
               sdr_req, h_wr_next, h_rd_valid, h_ack, arb_err, sdr_req_adr, sdr_wr_en_n);
    end
    m_last = 1;
    nxt();
    clr();
    s_resetn = 1'b1;
    nxt();
    serve_burst(pick(h_req), 0, 1'b0, 1'b1);
    nxt();
    serve_burst(pick(h_req), 1, 1'b0, 1'b1);
    nxt();
  endtask

  initial begin
    for (int h = 0; h < 2; h++) begin
      set_host(h, '0, 2'd0, 1'b1);
      hwd[h] = '0;
      hbe[h] = 4'hF;
    end
    @(negedge mclk);
    test_reset();
    test_alternate();
    test_write_burst();
    test_init_block();
    test_len0_coincident();
    test_init_drop();
    test_random();
    test_err();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sdc_host_arb.md
Name: sdc_host_arb

Overview:
- Two-host arbiter that sits directly upstream of sdc_top and drives its single host request/data interface.
- Grants one host at a time, round-robin, and presents that host's request to the controller.
- Steers the per-beat write-data and read-data strobes to the owning host until the burst completes.
- Lets two agents (e.g. CPU and DMA) share one SDRAM controller.

Parameters:
AW, 22, host byte-address width (matches sdr_req_adr)
DW, 32, host data width (matches sdr_wr_data/sdr_rd_data)

Ports:
mclk  in  1  system clock, all logic on rising edge
s_resetn  in  1  asynchronous active-low reset
h_req  in  2  per-host request (bit i = host i)
h_adr  in  2*AW  per-host address, host i at [i*AW +: AW]
h_len  in  4  per-host burst length code, host i at [2i+1:2i]
h_wr_n  in  2  per-host direction, 0 = write
h_wr_data  in  2*DW  per-host write data
h_wr_en_n  in  8  per-host byte enables (active low), 4 bits per host
h_ack  out  2  one-cycle request accept pulse to host i
h_wr_next  out  2  write-data-consumed strobe to host i
h_rd_valid  out  2  read-data-valid strobe to host i
h_rd_data  out  DW  read data, broadcast to both hosts
sdr_init_done  in  1  controller initialisation complete
sdr_req  out  1  request to controller
sdr_req_adr  out  AW  granted address
sdr_req_len  out  2  granted length code
sdr_req_wr_n  out  1  granted direction
sdr_wr_data  out  DW  owner's write data
sdr_wr_en_n  out  4  owner's byte enables
sdr_req_ack  in  1  controller accepted request
sdr_wr_next  in  1  controller consumed one write beat
sdr_rd_valid  in  1  controller presents one read beat
sdr_rd_data  in  DW  controller read data
arb_err  out  1  sticky: data strobe seen with no owner

Behaviour:
- Reset: state IDLE; owner 0; last_grant 1 (host 0 wins the first tie); beat counter 0; arb_err 0; sdr_req 0; sdr_req_adr, sdr_req_len, sdr_req_wr_n registered to 0; h_ack 0.
- Beats per burst = h_len + 1 (code 0..3 gives 1..4 beats). Counter is 2 bits; done when count == len on a counted strobe.
- IDLE state:
  - No grant while sdr_init_done = 0.
  - Otherwise the requesting host is granted. If both request, the host != last_grant is granted.
  - On grant, register that host's adr/len/wr_n into the sdr_req_* outputs, set owner and last_grant, assert sdr_req next cycle, and go to REQ.
  - Grant decision to sdr_req high takes 1 cycle.
- REQ state:
  - sdr_req held high with stable fields until sdr_req_ack.
  - On ack: sdr_req drops next cycle, h_ack[owner] pulses for exactly that one ack cycle (combinational from ack and owner), and state goes to XFER.
  - Host must hold h_req and its fields until h_ack. Deasserting h_req before ack does not cancel the request.
- Strobe steering in REQ and XFER:
  - h_wr_next[owner] = sdr_wr_next and h_rd_valid[owner] = sdr_rd_valid, combinational; non-owner strobes are 0.
  - sdr_wr_data and sdr_wr_en_n are combinational muxes of the owner's inputs.
  - h_rd_data = sdr_rd_data always.
  - Only the strobe matching sdr_req_wr_n is counted; the other strobe is still forwarded but not counted.
  - In IDLE, sdr_wr_data = 0 and sdr_wr_en_n = 4'hF.
- XFER state: counts beats. On the final counted beat, go to IDLE, and a new grant may be made the cycle after.
- Boundary conditions:
  - Ack and final beat in the same cycle (len 0, strobe coincident with ack): count it and go directly REQ to IDLE.
  - Strobe before ack in REQ: counted.
  - sdr_wr_next or sdr_rd_valid while IDLE: ignored for steering, sets arb_err (cleared only by reset).
  - A host requesting continuously while the other is idle is re-granted every burst (no forced gap beyond the IDLE cycle).
  - sdr_init_done falling mid-burst: the burst completes normally; new grants are blocked.
  - Async reset mid-burst: all state returns to reset values immediately; sdr_req drops asynchronously.

Test Plan:
- Host0 write, len=3, adr=0x000100, init_done=1 -> sdr_req high 1 cycle after h_req; sdr_req_adr=0x000100, len=3, wr_n=0; h_ack[0] pulses on ack; 4 sdr_wr_next produce 4 h_wr_next[0] with sdr_wr_data = h0 data each beat; h_wr_next[1] stays 0; IDLE after 4th beat.
- Both hosts request reads, len=1, held continuously -> grants alternate 0,1,0,1; each burst yields exactly 2 h_rd_valid pulses to the owner only; h_rd_data = sdr_rd_data.
- h_req[0]=1 while sdr_init_done=0 for 20 cycles -> sdr_req stays 0; grant 1 cycle after init_done rises.
- Host1 read len=0, sdr_rd_valid coincident with sdr_req_ack -> h_ack[1] and h_rd_valid[1] in the same cycle; return to IDLE; next request granted 1 cycle later.
- sdr_wr_next pulse with no request pending -> no h_wr_next asserted; arb_err=1 and stays 1 until s_resetn low.
- s_resetn asserted in XFER after beat 2 of 4 -> sdr_req=0, h_* strobes 0, arb_err 0 immediately; after release, host0 wins a simultaneous request.
